id_inst_buffer: RTL and testbench

Parametrised instruction buffer between the instruction-cache return path and the ID decoder. It replaces the single ID pipeline register with a DEPTH-entry FIFO of {pc, inst, delay_slot}. Delay-slot marking comes from a built-in branch/jump predecoder. Full flushes drop every entry; branch redirects drop every entry except the branch's delay slot.

---
 rtl/id_inst_buffer_pkg.sv | 13 +
 rtl/id_inst_buffer_if.sv | 19 +
 rtl/id_inst_buffer_br_predecode.sv | 18 +
 rtl/id_inst_buffer.sv | 84 ++++++++
 tb/tb_id_inst_buffer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_inst_buffer_pkg.sv
// id_inst_buffer_pkg: opcode/funct/rt constants shared with ID decode, buffer FSM states, entry type
package id_inst_buffer_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  typedef enum logic {NORMAL, WAIT_SLOT} ibuf_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        delay_slot;
  } ibuf_entry_t;
endpackage

// File: rtl/id_inst_buffer_if.sv
// id_inst_buffer_if: cache-return / decoder handshake bundle; master = fetch+decode side, slave = buffer
interface id_inst_buffer_if #(parameter int PC_W = 32, parameter int INST_W = 32, parameter int CNT_W = 3);
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_ack;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_delay_slot;
  logic              out_ready;
  logic              flush;
  logic              redirect;
  logic [CNT_W-1:0]  count;
  modport master (output in_valid, in_pc, in_inst, out_ready, flush, redirect,
                  input in_ack, out_valid, out_pc, out_inst, out_delay_slot, count);
  modport slave (input in_valid, in_pc, in_inst, out_ready, flush, redirect,
                 output in_ack, out_valid, out_pc, out_inst, out_delay_slot, count);
endinterface

// File: rtl/id_inst_buffer_br_predecode.sv
// br_predecode: flags branch/jump instructions so the following entry can be marked as a delay slot
module br_predecode
  import id_inst_buffer_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_ctrl_transfer
);
  logic [5:0] op, fn;
  logic [4:0] rt;
  logic unused_bits;
  assign op = inst[31:26];
  assign rt = inst[20:16];
  assign fn = inst[5:0];
  assign unused_bits = ^{inst[25:21], inst[15:6]};
  assign is_ctrl_transfer = (op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ})
                          | (op == OP_REGIMM && (rt inside {RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL}))
                          | (op == OP_SPECIAL && (fn inside {FN_JR, FN_JALR}));
endmodule

// File: rtl/id_inst_buffer.sv
// id_inst_buffer: DEPTH-entry {pc, inst, delay_slot} FIFO between icache return and ID decode.
// Define IBUF_BYPASS_EN to let a push into an empty buffer reach out_* in the same cycle.
module id_inst_buffer
  import id_inst_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter int INST_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'hbfc00000
) (
  input logic clk,
  input logic resetn,
  id_inst_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  logic [PC_W-1:0]   pc_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]  ds_mem;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, nxt_ptr;
  logic [CNT_W-1:0]  cnt;
  ibuf_state_t       state;
  logic last_br, is_br, empty, full, ack, push, pop, byp, wr, rd, vld, in_ds, slot_next;
  br_predecode u_pre (.inst(bus.in_inst), .is_ctrl_transfer(is_br));
  assign empty = cnt == '0;
  assign full = cnt == FULL_CNT;
  assign ack = resetn & !full & !bus.flush & !bus.redirect;
  assign push = bus.in_valid & ack;
`ifdef IBUF_BYPASS_EN
  assign byp = empty & push & (state == NORMAL);
`else
  assign byp = 1'b0;
`endif
  assign vld = !empty | byp;
  assign pop = vld & bus.out_ready;
  // a bypassed entry consumed in its own cycle never touches storage
  assign wr = push & !(byp & bus.out_ready);
  assign rd = pop & !byp;
  assign in_ds = (state == WAIT_SLOT) | last_br;
  assign nxt_ptr = rd_ptr + 1'b1;
  assign slot_next = (cnt > CNT_W'(1)) & ds_mem[nxt_ptr];
  assign bus.in_ack = ack;
  assign bus.out_valid = vld;
  assign bus.out_pc = !vld ? RESET_PC : byp ? bus.in_pc : pc_mem[rd_ptr];
  assign bus.out_inst = !vld ? '0 : byp ? bus.in_inst : inst_mem[rd_ptr];
  assign bus.out_delay_slot = vld & (byp ? in_ds : ds_mem[rd_ptr]);
  assign bus.count = cnt;
  always_ff @(posedge clk)
    if (wr) begin
      pc_mem[wr_ptr] <= bus.in_pc;
      inst_mem[wr_ptr] <= bus.in_inst;
      ds_mem[wr_ptr] <= in_ds;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      last_br <= 1'b0;
      state <= NORMAL;
    end else if (bus.flush) begin
      cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      last_br <= 1'b0;
      state <= NORMAL;
    end else if (bus.redirect) begin
      last_br <= 1'b0;
      // keep only the delay slot sitting right behind the branch, else wait for it to arrive
      rd_ptr <= slot_next ? nxt_ptr : wr_ptr;
      wr_ptr <= slot_next ? nxt_ptr + 1'b1 : wr_ptr;
      cnt <= slot_next ? CNT_W'(1) : '0;
      state <= slot_next ? NORMAL : WAIT_SLOT;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= nxt_ptr;
      cnt <= cnt + CNT_W'(wr) - CNT_W'(rd);
      if (push) begin
        last_br <= (state == NORMAL) & is_br;
        state <= NORMAL;
      end
    end
endmodule

// File: tb/tb_id_inst_buffer.sv
// tb_id_inst_buffer: directed self-checking bench for id_inst_buffer (DEPTH=4)
module tb_id_inst_buffer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  localparam logic [31:0] NOP = 32'h0;
  localparam logic [31:0] BEQ = 32'h10820003;
  id_inst_buffer_if #(.PC_W(32), .INST_W(32), .CNT_W(3)) bus ();
  id_inst_buffer #(.DEPTH(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_inst = '0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    bus.redirect = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_pc = pc;
    bus.in_inst = inst;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_pc !== 32'hbfc00000) begin bad++; $display("FAIL reset_pc: got %h want bfc00000", bus.out_pc); end
    total++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", bus.out_inst); end
    total++; if (bus.out_delay_slot !== 1'b0) begin bad++; $display("FAIL reset_ds: got %b want 0", bus.out_delay_slot); end
    total++; if (bus.in_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", bus.in_ack); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc = 32'(i * 4);
      bus.in_inst = NOP;
      #1;
      total++; if (bus.in_ack !== 1'b1) begin bad++; $display("FAIL fill_ack%0d: got %b want 1", i, bus.in_ack); end
      tick();
    end
    bus.in_pc = 32'h10;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", bus.count); end
    total++; if (bus.in_ack !== 1'b0) begin bad++; $display("FAIL full_ack_with_pop: got %b want 0", bus.in_ack); end
    total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL fill_head0: got %h want 0", bus.out_pc); end
    tick();
    total++; if (bus.in_ack !== 1'b1) begin bad++; $display("FAIL fifth_ack: got %b want 1", bus.in_ack); end
    total++; if (bus.out_pc !== 32'h4) begin bad++; $display("FAIL fill_head1: got %h want 4", bus.out_pc); end
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL after_pop_count: got %0d want 3", bus.count); end
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL push_pop_count: got %0d want 3", bus.count); end
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(8 + 4 * i) || bus.out_delay_slot !== 1'b0) begin
        bad++; $display("FAIL drain%0d: got v=%b pc=%h ds=%b want v=1 pc=%h ds=0", i, bus.out_valid, bus.out_pc, bus.out_delay_slot, 32'(8 + 4 * i));
      end
      tick();
    end
    total++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'hbfc00000 || bus.count !== 3'd0) begin
      bad++; $display("FAIL drained: got v=%b pc=%h cnt=%0d want v=0 pc=bfc00000 cnt=0", bus.out_valid, bus.out_pc, bus.count);
    end
    idle();
  endtask

  task automatic test_predecode();
    logic [31:0] insts [14] = '{BEQ, NOP, 32'h03e00008, NOP, 32'h04110002, 32'h00851021, 32'h04020001,
                                32'h0c000040, 32'h1c400002, NOP, NOP, 32'h0040f809, NOP, NOP};
    logic exp_ds [14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      bus.in_valid = k < 14;
      bus.in_pc = 32'h100 + 32'(4 * k);
      bus.in_inst = k < 14 ? insts[k] : NOP;
      #1;
      if (k > 0) begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 + 32'(4 * (k - 1)) || bus.out_inst !== insts[k-1]
                     || bus.out_delay_slot !== exp_ds[k-1] || bus.count !== 3'd1) begin
          bad++; $display("FAIL stream%0d: got v=%b pc=%h inst=%h ds=%b cnt=%0d want v=1 pc=%h inst=%h ds=%b cnt=1", k - 1,
                          bus.out_valid, bus.out_pc, bus.out_inst, bus.out_delay_slot, bus.count,
                          32'h100 + 32'(4 * (k - 1)), insts[k-1], exp_ds[k-1]);
        end
      end
      tick();
    end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL stream_end_count: got %0d want 0", bus.count); end
    idle();
  endtask

  task automatic test_redirect_slot();
    push(32'h100, BEQ);
    push(32'h104, NOP);
    push(32'h108, NOP);
    bus.redirect = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h10c;
    #1;
    total++; if (bus.in_ack !== 1'b0) begin bad++; $display("FAIL redirect_ack: got %b want 0", bus.in_ack); end
    total++; if (bus.count !== 3'd3 || bus.out_pc !== 32'h100) begin bad++; $display("FAIL redirect_pre: got cnt=%0d pc=%h want 3 100", bus.count, bus.out_pc); end
    tick();
    idle();
    #1;
    total++; if (bus.count !== 3'd1 || bus.out_pc !== 32'h104 || bus.out_delay_slot !== 1'b1) begin
      bad++; $display("FAIL redirect_keep_slot: got cnt=%0d pc=%h ds=%b want 1 104 1", bus.count, bus.out_pc, bus.out_delay_slot);
    end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL redirect_slot_pop: got %0d want 0", bus.count); end
    idle();
  endtask

  task automatic test_redirect_wait();
    push(32'h200, BEQ);
    bus.redirect = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    idle();
    #1;
    total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL wait_empty: got cnt=%0d v=%b want 0 0", bus.count, bus.out_valid); end
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h204;
    bus.in_inst = NOP;
    #1;
    total++; if (bus.in_ack !== 1'b1) begin bad++; $display("FAIL wait_ack: got %b want 1", bus.in_ack); end
    tick();
    push(32'h208, NOP);
    #1;
    total++; if (bus.count !== 3'd2 || bus.out_pc !== 32'h204 || bus.out_delay_slot !== 1'b1) begin
      bad++; $display("FAIL wait_slot_marked: got cnt=%0d pc=%h ds=%b want 2 204 1", bus.count, bus.out_pc, bus.out_delay_slot);
    end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_pc !== 32'h208 || bus.out_delay_slot !== 1'b0) begin
      bad++; $display("FAIL wait_after_slot: got pc=%h ds=%b want 208 0", bus.out_pc, bus.out_delay_slot);
    end
    tick();
    idle();
  endtask

  task automatic test_flush();
    push(32'h400, NOP);
    push(32'h404, NOP);
    push(32'h408, BEQ);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h40c;
    #1;
    total++; if (bus.in_ack !== 1'b0 || bus.count !== 3'd3) begin bad++; $display("FAIL flush_req: got ack=%b cnt=%0d want 0 3", bus.in_ack, bus.count); end
    tick();
    idle();
    #1;
    total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'hbfc00000 || bus.out_inst !== 32'h0) begin
      bad++; $display("FAIL flush_state: got cnt=%0d v=%b pc=%h inst=%h want 0 0 bfc00000 0", bus.count, bus.out_valid, bus.out_pc, bus.out_inst);
    end
    push(32'h500, NOP);
    #1;
    total++; if (bus.out_pc !== 32'h500 || bus.out_delay_slot !== 1'b0) begin
      bad++; $display("FAIL flush_clears_last_br: got pc=%h ds=%b want 500 0", bus.out_pc, bus.out_delay_slot);
    end
    bus.out_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_latency();
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h300;
    bus.in_inst = 32'h24020001;
    bus.out_ready = 1'b1;
    #1;
`ifdef IBUF_BYPASS_EN
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300 || bus.out_inst !== 32'h24020001) begin
      bad++; $display("FAIL bypass_same_cycle: got v=%b pc=%h inst=%h want 1 300 24020001", bus.out_valid, bus.out_pc, bus.out_inst);
    end
    tick();
    idle();
    total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL bypass_count: got cnt=%0d v=%b want 0 0", bus.count, bus.out_valid); end
`else
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL no_bypass_same_cycle: got %b want 0", bus.out_valid); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300 || bus.count !== 3'd1) begin
      bad++; $display("FAIL latency_one: got v=%b pc=%h cnt=%0d want 1 300 1", bus.out_valid, bus.out_pc, bus.count);
    end
    tick();
    idle();
`endif
  endtask

  task automatic test_async_reset();
    push(32'h600, NOP);
    push(32'h604, NOP);
    total++; if (bus.count !== 3'd2 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset: got cnt=%0d v=%b want 2 1", bus.count, bus.out_valid); end
    resetn = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.in_ack !== 1'b0) begin
      bad++; $display("FAIL async_reset: got v=%b cnt=%0d ack=%b want 0 0 0", bus.out_valid, bus.count, bus.in_ack);
    end
    tick();
    resetn = 1'b1;
    tick();
    total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ack !== 1'b1) begin
      bad++; $display("FAIL post_reset: got cnt=%0d v=%b ack=%b want 0 0 1", bus.count, bus.out_valid, bus.in_ack);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_predecode();
    test_redirect_slot();
    test_redirect_wait();
    test_flush();
    test_latency();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
